// File: rtl/mux8_1_reg.sv
// -----------------------------------------------------------------------------
// mux8_1_reg
//
// Eight-way WIDTH-bit data selector with two views of the selected word:
//   - mux_out  : combinational, zero latency. For glue logic that needs the
//                word in the same cycle.
//   - out_data : registered one cycle later. out_sel carries the select that
//                produced it, and out_valid marks a new word.
//
// Ports
//   clk       in   1      system clock, rising edge active
//   rst_n     in   1      synchronous, active-low reset
//   in_valid  in   1      qualifies sel/in0..in7 for capture this cycle
//   in0..in7  in   WIDTH  data words, in<n> selected when sel == n
//   sel       in   3      binary select, sel[0] is the LSB
//   mux_out   out  WIDTH  combinational selected word
//   out_data  out  WIDTH  registered selected word
//   out_valid out  1      out_data holds a word captured on the last edge
//   out_sel   out  3      sel value captured together with out_data
//
// Handshake: the input side is valid-only. A word is captured on every rising
// edge where rst_n=1 and in_valid=1. The output side is also valid-only.
// out_valid is high for exactly the one cycle after each capture. There is no
// ready signal, so the consumer must take out_data in every cycle where
// out_valid=1. When no capture happens, out_data and out_sel keep their last
// values but are no longer marked valid.
// -----------------------------------------------------------------------------
module mux8_1_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [2:0]       out_sel
);

  // All eight select codes are decoded explicitly. The default assignment
  // only keeps the block latch-free and is never the result for a 0/1 select.
  always_comb begin
    mux_out = '0;
    case (sel)
      3'b000: mux_out = in0;
      3'b001: mux_out = in1;
      3'b010: mux_out = in2;
      3'b011: mux_out = in3;
      3'b100: mux_out = in4;
      3'b101: mux_out = in5;
      3'b110: mux_out = in6;
      3'b111: mux_out = in7;
      default: mux_out = '0;
    endcase
  end

  // Reset takes priority over in_valid. A word presented during reset is
  // dropped, not delayed. When no capture happens, only the valid flag clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= 3'd0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out_data  <= mux_out;
      out_sel   <= sel;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8_1_reg.sv
`timescale 1ns/100ps
module tb_mux8_1_reg;

  localparam int WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid;
  logic [2:0]       sel;
  logic [WIDTH-1:0] d [8];
  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [2:0]       out_sel;

  mux8_1_reg #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in0      (d[0]),
    .in1      (d[1]),
    .in2      (d[2]),
    .in3      (d[3]),
    .in4      (d[4]),
    .in5      (d[5]),
    .in6      (d[6]),
    .in7      (d[7]),
    .sel      (sel),
    .mux_out  (mux_out),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_sel  (out_sel)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  // Each entry is {sel, data}, pushed when a capture is driven.
  logic [WIDTH+2:0] exp_q[$];
  logic [WIDTH-1:0] hold_d;
  logic [2:0]       hold_s;

  logic [WIDTH-1:0] sweep_vals [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // The reference word comes from the bench's own data array.
  function automatic logic [WIDTH-1:0] model_mux(input logic [2:0] s);
    return d[s];
  endfunction

  // Advances one clock. The current inputs are applied at the edge, and the
  // registered outputs are checked 1 ns after it.
  task automatic tick(input string tag);
    logic r;
    logic v;
    logic [WIDTH+2:0] e;
    r = rst_n;
    v = in_valid;
    if (r && v) exp_q.push_back({sel, model_mux(sel)});
    @(posedge clk);
    #1;
    if (!r) begin
      exp_q.delete();
      hold_d = '0;
      hold_s = 3'd0;
      chk({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_rst_data"},  32'(out_data),  32'd0);
      chk({tag, "_rst_sel"},   32'(out_sel),   32'd0);
    end else if (v) begin
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        hold_d = e[WIDTH-1:0];
        hold_s = e[WIDTH+2:WIDTH];
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(hold_d));
        chk({tag, "_sel"},   32'(out_sel),   32'(hold_s));
      end
    end else begin
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_hold_data"},  32'(out_data),  32'(hold_d));
      chk({tag, "_hold_sel"},   32'(out_sel),   32'(hold_s));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sweep_vals[0] = 16'h3524; sweep_vals[1] = 16'h5E81;
    sweep_vals[2] = 16'hD609; sweep_vals[3] = 16'h5663;
    sweep_vals[4] = 16'h7B0D; sweep_vals[5] = 16'h998D;
    sweep_vals[6] = 16'h8465; sweep_vals[7] = 16'h5212;
    for (int i = 0; i < 8; i++) d[i] = sweep_vals[i];
    hold_d = '0;
    hold_s = 3'd0;

    // Reset for two cycles with a capture attempt in flight.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    sel      = 3'd5;
    d[5]     = 16'hBEEF;
    #1;
    chk("reset_mux_pre", 32'(mux_out), 32'h0000BEEF);
    for (int i = 0; i < 2; i++) begin
      tick("reset");
      chk("reset_mux", 32'(mux_out), 32'h0000BEEF);
    end
    d[5] = sweep_vals[5];

    // Combinational sweep between edges, with in_valid low so nothing is captured.
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      #0.5;
      chk("comb_sweep", 32'(mux_out), 32'(sweep_vals[i]));
      #0.5;
    end
    tick("sweep_idle");

    // Back-to-back captures while sel walks 0..7.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick("walk");
    end

    // Hold: capture sel=3, then drop in_valid with sel=6.
    sel = 3'd3;
    tick("cap3");
    in_valid = 1'b0;
    sel      = 3'd6;
    tick("hold");
    chk("hold_mux", 32'(mux_out), 32'h00008465);
    chk("hold_data_const", 32'(out_data), 32'h00005663);

    // Only the data changes while sel stays at 7.
    in_valid = 1'b1;
    sel      = 3'd7;
    d[7] = 16'h5212; tick("data7");
    d[7] = 16'hFFFF; tick("data7");
    d[7] = 16'h0000; tick("data7");
    d[7] = sweep_vals[7];

    // Reset in the middle of a stream of captures.
    sel = 3'd1; tick("stream");
    sel = 3'd2; rst_n = 1'b0; tick("midrst");
    rst_n = 1'b1;
    sel = 3'd4; tick("resume");
    sel = 3'd5; tick("resume");

    // Random back-to-back traffic with in_valid toggling.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 8; k++) d[k] = WIDTH'($urandom_range(0, 16'hFFFF));
      sel      = 3'($urandom_range(0, 7));
      in_valid = 1'($urandom_range(0, 1));
      #1;
      chk("rand_mux", 32'(mux_out), 32'(d[sel]));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
